uart_tx_param: RTL
==================

# uart_tx_param

Parametrised UART transmitter that serialises one word per valid/ready handshake into an asynchronous frame. Each frame is a start bit, DATA_W data bits LSB-first, an optional parity bit and one or two stop bits. It generalises the team's fixed 8-bit transmitter with configurable width, bit period, parity and stop-bit count, plus a proper backpressure handshake. It sits between a byte/word source (FIFO or CPU register) and the serial pin.

## Interface
- DATA_W, 8, data bits per frame (5..9)
- CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, number of stop bits (1 or 2)

- clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- din  in  DATA_W  word to send; sampled only on handshake
- valid  in  1  source has a word on din
- ready  out  1  high while in IDLE; handshake completes when valid && ready at a clk edge
- tx  out  1  serial line; idle and stop level is high
- busy  out  1  high from the cycle after the handshake until the frame ends
- done  out  1  one-cycle pulse at the end of the last stop bit

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- IDLE
  - tx=1, ready=1, busy=0.
  - On valid && ready: capture din into the shift register and compute the parity bit from din.
  - Clear the bit-period and bit-index counters; go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA
  - tx = shift[0] for CLKS_PER_BIT cycles per bit; shift right at each bit boundary.
  - After DATA_W bits, go to PAR if PARITY != 0, else STOP.
- PAR
  - tx = parity bit for CLKS_PER_BIT cycles.
  - Even: XOR of data bits. Odd: inverted XOR.
- STOP
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the final edge: go to IDLE and assert done for exactly one cycle.
- Frame length is (1 + DATA_W + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Changes on din after the handshake do not affect the frame in flight.
- valid while busy is ignored (ready=0). The word is not queued; the source holds it.
- tx is driven from a register and must be glitch-free.
- Unsupported parameter values (PARITY=3, STOP_BITS=0 or 3, CLKS_PER_BIT<2) are an elaboration error.

## Timing
- Reset values (the cycle after rst is sampled high):
  - state = IDLE, tx=1, ready=1, busy=0, done=0.
  - Shift register and counters = 0.
- Reset mid-frame:
  - Abort immediately; tx=1 on the next cycle.
  - No done pulse; no partial stop bit is required.
- Latency:
  - Handshake edge at cycle N; tx falls (start bit) and busy rises at cycle N+1.
- done and ready:
  - done is high in the first IDLE cycle after the final stop cycle.
  - ready is high in that same cycle.
- Back-to-back:
  - valid held high gives a new handshake in the done cycle.
  - The next start bit begins one clk later, so the line stays high exactly one clk beyond the stop bits.
- Bit-period counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); a bit boundary occurs at terminal count.
- Bit-index counter width $clog2(DATA_W+1). In STOP it counts stop bits.
- rst has priority over a simultaneous handshake.

## Structure
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PAR, STOP).
  - Parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - Also used by the future receiver.
- One sub-module: uart_baud_cnt.
  - Parametrised by CLKS_PER_BIT.
  - Inputs: clk, rst, clear.
  - Output: tick, a one-cycle pulse at terminal count.
  - Shared with the receiver.
- Remaining logic (FSM, shift register, parity, handshake) lives in uart_tx_param.

## Test plan
- Basic frame: DATA_W=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0xA5.
  - tx bit sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 clk.
  - done pulses 40 clk after tx falls; ready is low throughout the frame.
- Even parity: PARITY=1; send 0x07 -> parity bit 1. Send 0x03 -> parity bit 0. Frame is 44 clk.
- Odd parity and two stop bits: PARITY=2, STOP_BITS=2, DATA_W=5; send 0x00.
  - tx = 0, 0×5, 1 (parity), 1, 1. Frame is 9*CLKS_PER_BIT.
- Back-to-back: valid held high with 0x55 then 0xAA.
  - Two correct frames.
  - Exactly one extra high clk between the second stop bit's end and the next start bit.
  - Exactly one done per frame.
- Reset mid-frame: assert rst during DATA bit 3.
  - Next cycle tx=1, ready=1, busy=0, no done.
  - A following 0x3C frame is correct.
- Busy drop: pulse valid with 0xFF mid-frame.
  - No handshake occurs and the in-flight frame is unchanged.
  - din changes during the frame have no effect on tx.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode constants,
// used by the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick at terminal count.
// Held at zero while clear is high so each bit period starts aligned.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one word per valid/ready handshake, sent as
// start bit, DATA_W data bits LSB-first, optional parity and 1 or 2 stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_W - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  if (PARITY < PAR_NONE || PARITY > PAR_ODD || STOP_BITS < 1 || STOP_BITS > 2 ||
      CLKS_PER_BIT < 2 || DATA_W < 5 || DATA_W > 9) begin : g_bad_params
    $error("uart_tx_param: unsupported parameter combination");
  end

  uart_state_t       state;
  logic [DATA_W-1:0] shift;
  logic              par_bit;
  logic [IW-1:0]     bit_idx;
  logic              tick;
  logic              clear;

  // Hold the bit timer at zero while idle so the start bit gets a full period.
  assign clear = (state == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      par_bit <= 1'b0;
      bit_idx <= '0;
      tx      <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid && ready) begin
            shift   <= din;
            par_bit <= (^din) ^ (PARITY == PAR_ODD);
            bit_idx <= '0;
            tx      <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx    <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          // tx is loaded one bit ahead so the line changes exactly on the boundary.
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY != PAR_NONE) begin
                tx    <= par_bit;
                state <= PAR;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
        PAR: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              done    <= 1'b1;
              ready   <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
